count_sequencer: RTL and testbench
==================================

Name: count_sequencer

Overview:
- Control unit for the board-level 8-bit up counter: turns raw push-button inputs into one-cycle command pulses and sequences the count.
- Per-button path: synchronize, debounce, rising-edge detect.
- Command FSM (IDLE/RUN/HALT) gates a prescaler that paces count increments.
- Sits between the board buttons and the LED/7-seg display of the count.

Parameters:
- WIDTH, 8, counter width in bits.
- DIV, 50_000_000, prescaler period in clk cycles per count tick while running (>=2).
- DB_CYCLES, 500_000, consecutive stable samples required to accept a button level change (>=2).

Ports:
- clk  in  1  system clock, all logic posedge.
- rst  in  1  asynchronous, active-low reset.
- btnStart  in  1  raw start button, asynchronous, active-high.
- btnStop  in  1  raw stop button, asynchronous, active-high.
- btnStep  in  1  raw single-step button, asynchronous, active-high.
- btnClr  in  1  raw clear button, asynchronous, active-high.
- wrapEn  in  1  1: wrap max->0 and keep running; 0: saturate at max and HALT. Quasi-static, sampled directly.
- count  out  WIDTH  current count value.
- running  out  1  high while FSM in RUN.
- halted  out  1  high while FSM in HALT.
- tick  out  1  one-cycle pulse on each prescaler-generated increment.
- tc  out  1  one-cycle pulse on the cycle count transitions from max (2^WIDTH-1).

Behaviour:
- Reset (rst=0, async): count=0, FSM=IDLE, running=0, halted=0, tick=0, tc=0, prescaler=0. All synchronizer, debounce and edge-detect state is 0.
- Button path, each button independent:
  - 2-flop synchronizer.
  - Debounced level toggles after synchronized level differs from it for DB_CYCLES consecutive cycles; any mismatch-free cycle restarts the stability count.
  - Press pulse: registered, high exactly 1 cycle, on debounced 0->1. Release produces no pulse. A held button yields one pulse only.
  - Latency: raw rise to pulse high = DB_CYCLES+3 clk edges for a clean input.
  - A button held through reset deassertion produces one pulse after debounce.
- Command priority when pulses coincide: clr > stop > start > step. Only the highest-priority pulse acts; lower ones are dropped.
- FSM:
  - IDLE: start->RUN. step->increment once (rules below). stop ignored.
  - RUN: stop->IDLE. step and start ignored.
  - HALT: only clr exits. start, stop and step ignored.
  - clr from any state: count=0, prescaler=0, FSM=IDLE on the next edge; tc not asserted.
- Prescaler:
  - Counts 0..DIV-1 only in RUN; held at 0 otherwise. Cleared on stop and clr.
  - tick=1 for the cycle after the prescaler value DIV-1, i.e. the increment is registered on the same edge that returns the prescaler to 0.
  - First tick lands DIV cycles after entering RUN.
- Increment (tick or IDLE step):
  - count<max: count+1.
  - count==max, wrapEn=1: count=0, tc=1 for 1 cycle, FSM state unchanged.
  - count==max, wrapEn=0: count stays max, tc=1 for 1 cycle. A RUN tick moves FSM to HALT; an IDLE step moves FSM to HALT.
  - tc fires only on an increment attempt at max.
- Outputs: running and halted are registered and decode FSM state. count, tick and tc are registered.
- Async reset mid-count or mid-debounce abandons all activity immediately; no pulses are emitted on reset release.

Test Plan (DB_CYCLES=4, DIV=3, WIDTH=8):
- Reset hold, then release with all buttons low -> count=0, running=0, halted=0, tick=0, tc=0 for 20 cycles.
- btnStart bounces 1-0-1 at 1-cycle spacing, then held high 10 cycles -> exactly one start pulse; running=1; tick every 3 cycles; count 0->1->2->3 over 9 cycles.
- btnStep in IDLE, 3 clean presses -> count=3, tick never asserted, running=0.
- wrapEn=0, preload count to 254 via steps, start -> count 255, then on the next tick tc=1 for 1 cycle, halted=1, running=0, count stays 255. btnStart ignored. btnClr -> count=0, IDLE.
- wrapEn=1 at 255 in RUN -> next tick: count=0, tc 1 cycle, running stays 1.
- btnClr and btnStop pulses on the same cycle while RUN at count=5 -> count=0, IDLE. Assert rst mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/count_sequencer.sv
// Push-button control for an up counter: each button is synchronized, debounced and
// edge-detected into a one-cycle command pulse that drives an IDLE/RUN/HALT sequencer.
`timescale 1ns/1ps
module count_sequencer #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 50_000_000,
    parameter int DB_CYCLES = 500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btnStart,
    input  logic             btnStop,
    input  logic             btnStep,
    input  logic             btnClr,
    input  logic             wrapEn,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             halted,
    output logic             tick,
    output logic             tc
);

    localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DBW-1:0]   DB_LAST    = DBW'(DB_CYCLES - 1);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] COUNT_MAX  = {WIDTH{1'b1}};

    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_STEP  = 2;
    localparam int B_CLR   = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    logic [3:0]          btn_s;
    logic [3:0]          sync1_q, sync2_q, db_q, db_d, db_prev_q, pulse_q;
    logic [3:0][DBW-1:0] db_cnt_q, db_cnt_d;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                tick_q, tick_d, tc_q, tc_d;
    logic                running_q, halted_q;
    logic                clr_s, stop_s, start_s, step_s, inc_s;

    assign btn_s = {btnClr, btnStep, btnStop, btnStart};

    // Debounce: a level change is accepted only after DB_CYCLES consecutive mismatching samples
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    // Button synchronizer, debounce and press-edge registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 4'b0000;
            sync2_q   <= 4'b0000;
            db_q      <= 4'b0000;
            db_prev_q <= 4'b0000;
            pulse_q   <= 4'b0000;
            db_cnt_q  <= '0;
        end else begin
            sync1_q   <= btn_s;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            pulse_q   <= db_q & ~db_prev_q;
            db_cnt_q  <= db_cnt_d;
        end
    end

    // Only the highest-priority coincident command survives: clr > stop > start > step
    assign clr_s   = pulse_q[B_CLR];
    assign stop_s  = pulse_q[B_STOP]  & ~pulse_q[B_CLR];
    assign start_s = pulse_q[B_START] & ~pulse_q[B_CLR] & ~pulse_q[B_STOP];
    assign step_s  = pulse_q[B_STEP]  & ~pulse_q[B_CLR] & ~pulse_q[B_STOP] & ~pulse_q[B_START];

    // Sequencer next state, prescaler and increment rules
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = '0;
        tick_d  = 1'b0;
        tc_d    = 1'b0;
        inc_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d = S_RUN;
                end else if (step_s) begin
                    inc_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (stop_s) begin
                    state_d = S_IDLE;
                end else if (presc_q == PRESC_LAST) begin
                    tick_d = 1'b1;
                    inc_s  = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An attempt at the top either wraps or parks the sequencer in HALT
        if (inc_s) begin
            if (count_q != COUNT_MAX) begin
                count_d = count_q + 1'b1;
            end else begin
                tc_d = 1'b1;
                if (wrapEn) begin
                    count_d = '0;
                end else begin
                    state_d = S_HALT;
                end
            end
        end else begin
            count_d = count_q;
        end

        if (clr_s) begin
            state_d = S_IDLE;
            count_d = '0;
            presc_d = '0;
            tick_d  = 1'b0;
            tc_d    = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            tc_q      <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            tc_q      <= tc_d;
            running_q <= (state_d == S_RUN);
            halted_q  <= (state_d == S_HALT);
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign halted  = halted_q;
    assign tick    = tick_q;
    assign tc      = tc_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with DB_CYCLES=4, DIV=3, WIDTH=8.
`timescale 1ns/1ps
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;      // {clr, step, stop, start}
    logic       wrap_en;
    logic [7:0] count;
    logic       running, halted, tick, tc;
    logic [11:0] outs_s;

    int tests_run    = 0;
    int tests_failed = 0;
    int tick_seen    = 0;
    int tc_seen      = 0;
    int tick_base, tc_base;

    count_sequencer #(.WIDTH(8), .DIV(3), .DB_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .btnStart (btn[0]),
        .btnStop  (btn[1]),
        .btnStep  (btn[2]),
        .btnClr   (btn[3]),
        .wrapEn   (wrap_en),
        .count    (count),
        .running  (running),
        .halted   (halted),
        .tick     (tick),
        .tc       (tc)
    );

    assign outs_s = {count, running, halted, tick, tc};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick === 1'b1) tick_seen++;
        if (tc === 1'b1) tc_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        cyc(10);
        btn[b] = 1'b0;
        cyc(12);
    endtask

    task automatic wait_running(input logic val, input int max_cyc, input string tag);
        int n = 0;
        while (running !== val && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, running}, {31'd0, val});
    endtask

    task automatic wait_count(input logic [7:0] val, input int max_cyc, input string tag);
        int n = 0;
        while (count !== val && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {24'd0, count}, {24'd0, val});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        btn = 4'b0000; wrap_en = 1'b0; rst = 1'b1;
        #1 rst = 1'b0;
        cyc(3);
        #2 check_eq("reset_outs", {20'd0, outs_s}, 32'd0);

        // Release with buttons low: nothing may happen
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("idle_after_rst", {20'd0, outs_s}, 32'd0);
        end

        // Bouncing start, then held: one RUN entry, tick every 3 cycles
        btn[0] = 1'b1; @(negedge clk); btn[0] = 1'b0; @(negedge clk); btn[0] = 1'b1;
        wait_running(1'b1, 20, "start_bounce_run");
        btn[0] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check_eq("run_tick", {31'd0, tick}, (k % 3 == 0) ? 32'd1 : 32'd0);
            check_eq("run_count", {24'd0, count}, k / 3);
        end
        check_eq("run_still", {31'd0, running}, 32'd1);

        // Clear from RUN, then single steps in IDLE
        press(3);
        check_eq("clr_count", {24'd0, count}, 32'd0);
        check_eq("clr_idle", {31'd0, running}, 32'd0);
        tick_base = tick_seen;
        btn[2] = 1'b1;
        cyc(7);
        check_eq("step_lat_before", {24'd0, count}, 32'd0);
        cyc(1);
        check_eq("step_lat_after", {24'd0, count}, 32'd1);
        cyc(2); btn[2] = 1'b0; cyc(12);
        press(2); press(2);
        check_eq("step3_count", {24'd0, count}, 32'd3);
        check_eq("step3_no_tick", tick_seen - tick_base, 32'd0);
        check_eq("step3_idle", {31'd0, running}, 32'd0);

        // A long hold is still a single press
        btn[2] = 1'b1; cyc(40); btn[2] = 1'b0; cyc(12);
        check_eq("held_one_step", {24'd0, count}, 32'd4);

        // Saturating path: preload 254 by steps, run into the top
        for (int i = 0; i < 250; i++) press(2);
        check_eq("preload_254", {24'd0, count}, 32'd254);
        tc_base = tc_seen;
        btn[0] = 1'b1;
        wait_running(1'b1, 20, "sat_run");
        btn[0] = 1'b0;
        cyc(3);
        check_eq("sat_255", {24'd0, count}, 32'd255);
        check_eq("sat_no_tc_yet", {31'd0, tc}, 32'd0);
        cyc(3);
        check_eq("sat_tc", {31'd0, tc}, 32'd1);
        check_eq("sat_halted", {31'd0, halted}, 32'd1);
        check_eq("sat_not_running", {31'd0, running}, 32'd0);
        check_eq("sat_hold_255", {24'd0, count}, 32'd255);
        cyc(1);
        check_eq("sat_tc_one_cycle", {31'd0, tc}, 32'd0);
        press(0);
        check_eq("halt_ignores_start", {30'd0, running, halted}, 32'd1);
        press(2);
        check_eq("halt_ignores_step", {24'd0, count}, 32'd255);
        check_eq("halt_tc_total", tc_seen - tc_base, 32'd1);
        press(3);
        check_eq("halt_clr", {20'd0, outs_s}, 32'd0);

        // Wrapping path: run 0..255 and over the top
        wrap_en = 1'b1;
        btn[0] = 1'b1;
        wait_running(1'b1, 20, "wrap_run");
        btn[0] = 1'b0;
        wait_count(8'd255, 1000, "wrap_reach_255");
        cyc(3);
        check_eq("wrap_count0", {24'd0, count}, 32'd0);
        check_eq("wrap_tc", {31'd0, tc}, 32'd1);
        check_eq("wrap_running", {30'd0, running, halted}, 32'd2);
        cyc(1);
        check_eq("wrap_tc_one_cycle", {31'd0, tc}, 32'd0);

        // Coincident clr and stop: clr wins
        wait_count(8'd5, 50, "reach_5");
        tc_base = tc_seen;
        btn[3] = 1'b1; btn[1] = 1'b1;
        cyc(8);
        check_eq("clr_stop_count", {24'd0, count}, 32'd0);
        check_eq("clr_stop_idle", {30'd0, running, halted}, 32'd0);
        btn[3] = 1'b0; btn[1] = 1'b0;
        cyc(12);
        check_eq("clr_stop_stays0", {24'd0, count}, 32'd0);
        check_eq("clr_no_tc", tc_seen - tc_base, 32'd0);

        // Coincident start and step in IDLE: start wins, no increment
        btn[0] = 1'b1; btn[2] = 1'b1;
        cyc(8);
        check_eq("start_step_run", {31'd0, running}, 32'd1);
        check_eq("start_step_count", {24'd0, count}, 32'd0);
        btn[0] = 1'b0; btn[2] = 1'b0;
        cyc(10);

        // Async reset mid-run, with start held across release
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_eq("async_rst_outs", {20'd0, outs_s}, 32'd0);
        btn[0] = 1'b1;
        cyc(3);
        rst = 1'b1;
        cyc(5);
        check_eq("rst_release_no_pulse", {31'd0, running}, 32'd0);
        wait_running(1'b1, 10, "held_through_rst");
        btn[0] = 1'b0;
        cyc(12);
        press(1);
        check_eq("stop_idle", {31'd0, running}, 32'd0);
        tick_base = tick_seen;
        cyc(10);
        check_eq("stop_no_ticks", tick_seen - tick_base, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
